mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port.
- Arbitrates between the two requesters and sequences each access through a small FSM, which accounts for the memory's fixed read latency.
- Returns read data to the winning requester and drives a pipeline stall to the core while any access is outstanding.
- Sits between rv_core (pc_o/inst_i and alu_o/DataW_o/MemRW_o/mem_i side) and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en_o (read) to valid mem_rdata_i; legal range 1..7.
- STARVE_MAX, 4, consecutive data grants, made while fetch waits, before fetch is forced to win.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i until grant
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch accepted (one-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (one-cycle pulse)
- if_rdata_o  out  DATA_W  fetch read data
- d_req_i  in  1  data request; held with payload until grant
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  data accepted (one-cycle pulse)
- d_rvalid_o  out  1  load data valid (one-cycle pulse)
- d_rdata_o  out  DATA_W  load read data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  core pipeline stall
- perf_if_o  out  32  fetch grant count (see Optional Feature)
- perf_d_o  out  32  data grant count
- perf_stall_o  out  32  stall cycle count

Behaviour:
- Reset (rst_i low, asynchronous):
  - all outputs 0; FSM to IDLE; starve counter 0; latched address/data/owner 0.
  - an in-flight read is discarded and produces no rvalid.
  - mem_en_o falls immediately.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: at a clock edge with any request, latch owner, address, we and wdata from the winner, then go to ACCESS. Without a request, stay in IDLE.
- Arbitration happens only in IDLE:
  - data wins over fetch by default.
  - fetch wins if starve_cnt == STARVE_MAX and both are requesting.
  - starve_cnt increments on a data grant made while if_req_i is high, saturating at STARVE_MAX.
  - starve_cnt clears on a fetch grant, or on any arbitration edge with if_req_i low.
- ACCESS (exactly 1 cycle):
  - mem_en_o = 1; mem_we_o/addr/wdata come from the latch.
  - winner's gnt_o = 1 (only in this cycle).
  - for a store, go to IDLE; there is no rvalid.
  - for a load or fetch, go to WAIT with wait counter = MEM_LAT-1.
- WAIT: the counter decrements each cycle. In the cycle where the counter is 0, mem_rdata_i is sampled into the rdata register at the edge and the FSM goes to RESP. WAIT lasts MEM_LAT cycles.
- RESP (1 cycle): the owner's rvalid_o = 1, then the FSM goes to IDLE.
  - if_rdata_o and d_rdata_o both show the shared rdata register; rvalid qualifies which one is valid.
  - the register holds its value until the next read.
- Read latency: request-sampling edge → ACCESS → WAIT (MEM_LAT cycles) → RESP. rvalid is high in cycle 2+MEM_LAT after the sampling edge.
- mem_en_o is 0 in IDLE, WAIT and RESP, and mem_we_o = 0 whenever mem_en_o = 0.
- stall_o = (state ∈ {ACCESS, WAIT}) or (state == IDLE and (if_req_i or d_req_i)); stall_o is low in RESP.
- A request that drops before its grant is legal: it is ignored if the drop happens before the sampling edge. Once latched, the access completes regardless of the request line.
- No accesses are pipelined: at most one is outstanding, and a new grant is never issued in the same cycle as RESP.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - perf_if_o counts fetch grants, perf_d_o counts data grants, perf_stall_o counts cycles with stall_o high.
  - all three are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: the three ports exist, are tied to 0, and no counter flops are synthesized.

Test Plan:
- Single fetch, addr 0x100, memory returns 0xDEADBEEF with MEM_LAT=2 → if_gnt_o pulses in cycle 1, mem_en_o=1 with mem_addr_o=0x100 in cycle 1, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF in cycle 4, stall_o high in cycles 0–3.
- Store d_addr 0x2000, wdata 0x12345678 → one mem_en_o=1 cycle with mem_we_o=1 and those values; d_gnt_o pulses; no d_rvalid_o; FSM back in IDLE the next cycle.
- Simultaneous fetch and load in the same cycle → data is granted first; fetch is granted only after the data RESP; the two rvalids never overlap.
- Fetch held continuously while 5 loads are queued back-to-back → grants are data ×4 then fetch, then the 5th data; starve_cnt returns to 0.
- rst_i pulled low during WAIT of a load → mem_en_o and all outputs go 0 immediately; after release there is no d_rvalid_o and the FSM is in IDLE.
- With MEM_ARB_PERF_EN, 3 fetches and 2 stores run → perf_if_o=3, perf_d_o=2, perf_stall_o equals the count of stall_o-high cycles; without the macro all three read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data ports.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined; otherwise perf ports are tied to 0.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       perf_if_o,
    output logic [31:0]       perf_d_o,
    output logic [31:0]       perf_stall_o
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic              pick_if;

    // Next-state, latch and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        pick_if     = if_req_i && (!d_req_i || (starve_q == STV_W'(STARVE_MAX)));
        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_d  = ACCESS;
                    mem_en_d = 1'b1;
                    if (pick_if) begin
                        owner_d  = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        if_gnt_d = 1'b1;
                        starve_d = '0;
                    end else begin
                        owner_d  = 1'b1;
                        we_d     = d_we_i;
                        addr_d   = d_addr_i;
                        wdata_d  = d_wdata_i;
                        d_gnt_d  = 1'b1;
                        mem_we_d = d_we_i;
                        if (!if_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != STV_W'(STARVE_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end else begin
                    starve_d = '0;
                end
            end
            ACCESS: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d     = mem_rdata_i;
                    state_d     = RESP;
                    d_rvalid_d  = owner_q;
                    if_rvalid_d = !owner_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign d_gnt_o     = d_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = rdata_q;
    assign d_rdata_o   = rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Stall must see a request in the same cycle it appears, so it is decoded from live inputs
    assign stall_o = rst_i && ((state_q == ACCESS) || (state_q == WAIT) ||
                               ((state_q == IDLE) && (if_req_i || d_req_i)));

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d, perf_d_q, perf_d_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_if_d    = perf_if_q;
        perf_d_d     = perf_d_q;
        perf_stall_d = perf_stall_q;
        if (if_gnt_q && (perf_if_q != 32'hFFFF_FFFF))  perf_if_d    = perf_if_q + 32'd1;
        if (d_gnt_q && (perf_d_q != 32'hFFFF_FFFF))    perf_d_d     = perf_d_q + 32'd1;
        if (stall_o && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_if_q    <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_if_q    <= perf_if_d;
            perf_d_q     <= perf_d_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_if_o    = perf_if_q;
    assign perf_d_o     = perf_d_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_if_o    = '0;
    assign perf_d_o     = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int unsigned MEM_LAT = 2;
    localparam int K_F  = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o, mem_we_o, stall_o;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [31:0] perf_if_o, perf_d_o, perf_stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] lat_addr = '0;
    int          lat_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .perf_if_o(perf_if_o), .perf_d_o(perf_d_o),
        .perf_stall_o(perf_stall_o)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Memory returns data only in the cycle exactly MEM_LAT after the read strobe
    always @(posedge clk) begin
        if (!rst_i) begin
            lat_cnt <= 0;
        end else if (mem_en_o && !mem_we_o) begin
            lat_addr <= mem_addr_o;
            lat_cnt  <= MEM_LAT;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end
    assign mem_rdata_i = (lat_cnt == 1) ? memfn(lat_addr) : 32'hBADB_AD00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (2) next_cycle();
        rst_i = 1'b1;
        next_cycle();
    endtask

    // One isolated access, checked cycle by cycle from the request-sampling edge
    task automatic run_txn(input vec_t v);
        if (v.kind == K_F) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = (v.kind == K_ST); d_addr = v.addr; d_wdata = v.wdata;
        end
        @(negedge clk);
        chk1("stall_c0", stall_o, 1'b1);
        chk1("gnt_c0", if_gnt_o | d_gnt_o, 1'b0);
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk1("if_gnt_c1", if_gnt_o, v.kind == K_F);
        chk1("d_gnt_c1", d_gnt_o, v.kind != K_F);
        chk1("mem_en_c1", mem_en_o, 1'b1);
        chk1("mem_we_c1", mem_we_o, v.kind == K_ST);
        chk("mem_addr_c1", mem_addr_o, v.addr);
        if (v.kind == K_ST) chk("mem_wdata_c1", mem_wdata_o, v.wdata);
        if (v.kind == K_ST) begin
            next_cycle();
            @(negedge clk);
            chk1("st_mem_en_c2", mem_en_o, 1'b0);
            chk1("st_stall_c2", stall_o, 1'b0);
            chk("st_state_idle", 32'(dut.state_q), 32'd0);
            next_cycle();
            @(negedge clk);
            chk1("st_no_rvalid", d_rvalid_o | if_rvalid_o, 1'b0);
        end else begin
            for (int c = 0; c < int'(MEM_LAT); c++) begin
                next_cycle();
                @(negedge clk);
                chk1("wait_mem_en", mem_en_o, 1'b0);
                chk1("wait_stall", stall_o, 1'b1);
                chk1("wait_rvalid", if_rvalid_o | d_rvalid_o, 1'b0);
            end
            next_cycle();
            @(negedge clk);
            chk1("resp_if_rvalid", if_rvalid_o, v.kind == K_F);
            chk1("resp_d_rvalid", d_rvalid_o, v.kind == K_LD);
            chk("resp_if_rdata", if_rdata_o, v.exp_rdata);
            chk("resp_d_rdata", d_rdata_o, v.exp_rdata);
            chk1("resp_stall", stall_o, 1'b0);
            next_cycle();
            @(negedge clk);
            chk1("post_rvalid", if_rvalid_o | d_rvalid_o, 1'b0);
        end
        next_cycle();
    endtask

    // Fetch held high while n_loads loads are queued back to back
    task automatic run_contention(input int n_loads, input string exp_order);
        string       got = "";
        int          dcnt = 0, if_rv = 0, d_rv = 0, overlap = 0, rdbad = 0;
        logic        sg_d, sg_if;
        logic [31:0] gaddr = '0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int cyc = 0; cyc < 200 && !(if_rv == 1 && d_rv == n_loads); cyc++) begin
            @(negedge clk);
            sg_d  = d_gnt_o;
            sg_if = if_gnt_o;
            if (sg_d) begin got = {got, "D"}; gaddr = d_addr; end
            if (sg_if) got = {got, "F"};
            if (if_rvalid_o && d_rvalid_o) overlap++;
            if (if_rvalid_o) begin
                if_rv++;
                if (if_rdata_o !== 32'hDEAD_BEEF) rdbad++;
            end
            if (d_rvalid_o) begin
                d_rv++;
                if (d_rdata_o !== memfn(gaddr)) rdbad++;
            end
            next_cycle();
            if (sg_d) begin
                dcnt++;
                if (dcnt == n_loads) d_req = 1'b0;
                else d_addr = d_addr + 32'd4;
            end
            if (sg_if) if_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        n_tests++;
        if (got != exp_order) begin
            n_fail++;
            $display("FAIL grant_order: got %s expected %s", got, exp_order);
        end
        chk("rvalid_overlap", 32'(overlap), 32'd0);
        chk("if_rvalid_count", 32'(if_rv), 32'd1);
        chk("d_rvalid_count", 32'(d_rv), 32'(n_loads));
        chk("contention_rdata", 32'(rdbad), 32'd0);
        chk("starve_cleared", 32'(dut.starve_q), 32'd0);
        next_cycle();
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{K_F,  32'h0000_0100, 32'h0,          32'hDEAD_BEEF};
        vecs[1] = '{K_ST, 32'h0000_2000, 32'h1234_5678,  32'h0};
        vecs[2] = '{K_LD, 32'h0000_2000, 32'h0,          32'h5A5A_7A5A};
        vecs[3] = '{K_F,  32'h0000_0104, 32'h0,          32'h5A5A_5B5E};
        vecs[4] = '{K_LD, 32'hFFFF_FFFC, 32'h0,          32'hA5A5_A5A6};
        vecs[5] = '{K_ST, 32'h0000_0000, 32'hFFFF_FFFF,  32'h0};

        // Outputs held low in reset even with requests pending
        if_req = 1'b1; d_req = 1'b1;
        #7;
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_mem_en", mem_en_o, 1'b0);
        chk1("rst_gnt", if_gnt_o | d_gnt_o, 1'b0);
        chk1("rst_rvalid", if_rvalid_o | d_rvalid_o, 1'b0);
        chk("rst_perf_stall", perf_stall_o, 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        run_contention(1, "DF");
        run_contention(5, "DDDDFD");

        // Reset during WAIT of a load discards the read
        begin
            int rv = 0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
            next_cycle();
            d_req = 1'b0;
            @(negedge clk);
            chk1("rw_mem_en_access", mem_en_o, 1'b1);
            next_cycle();
            #2 rst_i = 1'b0;
            #1;
            chk1("rw_mem_en", mem_en_o, 1'b0);
            chk("rw_mem_addr", mem_addr_o, 32'h0);
            chk1("rw_stall", stall_o, 1'b0);
            chk1("rw_gnt", d_gnt_o | if_gnt_o, 1'b0);
            next_cycle();
            rst_i = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (d_rvalid_o || if_rvalid_o) rv++;
            end
            chk("rw_no_rvalid", 32'(rv), 32'd0);
            chk("rw_state_idle", 32'(dut.state_q), 32'd0);
            next_cycle();
        end

        // Reset during ACCESS of a store drops the strobe at once
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFE_F00D;
        next_cycle();
        d_req = 1'b0;
        #2;
        chk1("ra_mem_en_before", mem_en_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk1("ra_mem_en", mem_en_o, 1'b0);
        chk1("ra_mem_we", mem_we_o, 1'b0);
        chk1("ra_gnt", d_gnt_o, 1'b0);
        next_cycle();
        rst_i = 1'b1;
        next_cycle();

        // Perf counters: 3 fetches (4 stall cycles each) + 2 stores (2 each) = 16
        do_reset();
        run_txn(vecs[0]);
        run_txn(vecs[1]);
        run_txn(vecs[3]);
        run_txn(vecs[5]);
        run_txn(vecs[0]);
        repeat (2) next_cycle();
        @(negedge clk);
`ifdef MEM_ARB_PERF_EN
        chk("perf_if", perf_if_o, 32'd3);
        chk("perf_d", perf_d_o, 32'd2);
        chk("perf_stall", perf_stall_o, 32'd16);
`else
        chk("perf_if", perf_if_o, 32'd0);
        chk("perf_d", perf_d_o, 32'd0);
        chk("perf_stall", perf_stall_o, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
